// File: rtl/mem_copy_engine_if.sv
// Bus bundle for mem_copy_engine: control handshake plus the single-port word RAM port.
// The optional checksum result appears only when MEM_COPY_CHECKSUM_EN is defined.
interface mem_copy_engine_if #(
  parameter int LEN_W = 16
);
  logic             start;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;
  logic             err;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_w_data;
  logic             mem_wr_en;
  logic [31:0]      mem_r_data;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [31:0]      checksum;
`endif

  // Engine side: takes requests and RAM read data, drives status and RAM requests.
  modport master (
    input  start, src_addr, dst_addr, len, mem_r_data,
`ifdef MEM_COPY_CHECKSUM_EN
    output checksum,
`endif
    output busy, done, err, mem_addr, mem_w_data, mem_wr_en
  );

  // Host/RAM side: issues requests, returns read data, observes status.
  modport slave (
    output start, src_addr, dst_addr, len, mem_r_data,
`ifdef MEM_COPY_CHECKSUM_EN
    input  checksum,
`endif
    input  busy, done, err, mem_addr, mem_w_data, mem_wr_en
  );
endinterface

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: copies len 32-bit words from src_addr to dst_addr over a
// single-port word RAM, one read cycle and one write cycle per word.
// Optional feature macro: MEM_COPY_CHECKSUM_EN (adds a running sum of words read).
// All outputs are flops; their next values are derived from the next state so
// the observable timing equals a state-decoded Moore output.
module mem_copy_engine #(
  parameter int LEN_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_en,
  mem_copy_engine_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      src_ptr_q, src_ptr_d;
  logic [31:0]      dst_ptr_q, dst_ptr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [31:0]      data_q, data_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_w_data_q, mem_w_data_d;
  logic             mem_wr_en_q, mem_wr_en_d;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [31:0]      checksum_q, checksum_d;
`endif

  logic             misaligned_s;

  assign misaligned_s = (bus.src_addr[1:0] != 2'b00) || (bus.dst_addr[1:0] != 2'b00);

  // State and datapath registers; everything returns to the idle/zero state on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      src_ptr_q    <= 32'h0000_0000;
      dst_ptr_q    <= 32'h0000_0000;
      cnt_q        <= {LEN_W{1'b0}};
      data_q       <= 32'h0000_0000;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_addr_q   <= 32'h0000_0000;
      mem_w_data_q <= 32'h0000_0000;
      mem_wr_en_q  <= 1'b0;
`ifdef MEM_COPY_CHECKSUM_EN
      checksum_q   <= 32'h0000_0000;
`endif
    end else begin
      state_q      <= state_d;
      src_ptr_q    <= src_ptr_d;
      dst_ptr_q    <= dst_ptr_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      mem_addr_q   <= mem_addr_d;
      mem_w_data_q <= mem_w_data_d;
      mem_wr_en_q  <= mem_wr_en_d;
`ifdef MEM_COPY_CHECKSUM_EN
      checksum_q   <= checksum_d;
`endif
    end
  end

  // Next-state and datapath updates; nothing moves unless clk_en is high.
  always_comb begin
    state_d   = state_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    err_d     = err_q;
`ifdef MEM_COPY_CHECKSUM_EN
    checksum_d = checksum_q;
`endif
    if (clk_en) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            src_ptr_d = bus.src_addr;
            dst_ptr_d = bus.dst_addr;
            cnt_d     = bus.len;
            err_d     = misaligned_s;
`ifdef MEM_COPY_CHECKSUM_EN
            checksum_d = 32'h0000_0000;
`endif
            // Misaligned or empty requests finish without touching memory.
            if (misaligned_s || (bus.len == {LEN_W{1'b0}})) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_READ;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_READ: begin
          data_d    = bus.mem_r_data;
          src_ptr_d = src_ptr_q + 32'd4;
`ifdef MEM_COPY_CHECKSUM_EN
          checksum_d = checksum_q + bus.mem_r_data;
`endif
          state_d   = ST_WRITE;
        end
        ST_WRITE: begin
          dst_ptr_d = dst_ptr_q + 32'd4;
          cnt_d     = cnt_q - LEN_W'(1);
          if (cnt_q != LEN_W'(1)) begin
            state_d = ST_READ;
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output values for the state being entered, so the flops present them in that state.
  always_comb begin
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
    mem_addr_d   = 32'h0000_0000;
    mem_w_data_d = 32'h0000_0000;
    mem_wr_en_d  = 1'b0;
    case (state_d)
      ST_READ: begin
        mem_addr_d = src_ptr_d;
      end
      ST_WRITE: begin
        mem_addr_d   = dst_ptr_d;
        mem_w_data_d = data_d;
        mem_wr_en_d  = 1'b1;
      end
      ST_IDLE, ST_DONE: begin
        mem_addr_d = 32'h0000_0000;
      end
      default: begin
        mem_addr_d = 32'h0000_0000;
      end
    endcase
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_w_data = mem_w_data_q;
  assign bus.mem_wr_en  = mem_wr_en_q;
`ifdef MEM_COPY_CHECKSUM_EN
  assign bus.checksum   = checksum_q;
`endif

endmodule
